// File: rtl/tetris_board_scanner.sv
// tetris_board_scanner
// Sweeps the tetris core's cell-query port across the whole playfield in
// row-major order, captures each returned cell kind into a local snapshot
// buffer and counts the non-empty cells of the finished snapshot. The display
// reads the snapshot through its own registered port.
//
// Optional build macro: TBS_DOUBLE_BUF_EN
//   defined   - front/back banks; captures fill the back bank, the banks
//               swap in the DONE cycle so the display never sees a torn frame.
//   undefined - single bank written in place (reads may see a partial frame).
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   start          request one full scan (sampled in IDLE only)
//   core_ready     core board contents valid; gates leaving IDLE/WAIT
//   q_x, q_y       query address presented to the core
//   q_kind         core's cell kind, QUERY_LAT cycles after q_x/q_y
//   rd_x, rd_y     display read address
//   rd_kind        snapshot cell, one cycle after rd_x/rd_y; 0 if out of range
//   busy           high in WAIT, SCAN, DRAIN
//   done           one-cycle pulse when a snapshot completes
//   occupied_cnt   non-empty cells in the last completed snapshot
module tetris_board_scanner #(
  parameter int QUERY_LAT = 1,
  parameter int COLS      = 10,
  parameter int ROWS      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       core_ready,
  output logic [3:0] q_x,
  output logic [4:0] q_y,
  input  logic [2:0] q_kind,
  input  logic [3:0] rd_x,
  input  logic [4:0] rd_y,
  output logic [2:0] rd_kind,
  output logic       busy,
  output logic       done,
  output logic [7:0] occupied_cnt
);

  localparam int         CELLS      = COLS * ROWS;
  localparam int         IDX_W      = $clog2(CELLS);
  localparam logic [3:0] X_LAST     = 4'(COLS - 1);
  localparam logic [4:0] Y_LAST     = 5'(ROWS - 1);
  localparam logic [3:0] COLS_L     = 4'(COLS);
  localparam logic [4:0] ROWS_L     = 5'(ROWS);
  localparam logic [1:0] DRAIN_LAST = (QUERY_LAT > 0) ? 2'(QUERY_LAT - 1) : 2'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, next_state;
  logic [1:0]       drain_cnt;
  logic [IDX_W-1:0] addr_idx;
  logic [7:0]       run_cnt;
  logic             scan_last;

  logic [IDX_W-1:0] addr_p0;
  logic             vld_p0;
  logic [IDX_W-1:0] cap_addr;
  logic             cap_vld;

  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;
  logic [2:0]       rd_cell;

  assign scan_last = (state == S_SCAN) && (q_x == X_LAST) && (q_y == Y_LAST);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = core_ready ? S_SCAN : S_WAIT;
      S_WAIT:  if (core_ready) next_state = S_SCAN;
      S_SCAN:  if (scan_last) next_state = (QUERY_LAT == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (drain_cnt == DRAIN_LAST) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign busy = (state == S_WAIT) || (state == S_SCAN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      q_x          <= 4'd0;
      q_y          <= 5'd0;
      addr_idx     <= '0;
      drain_cnt    <= 2'd0;
      run_cnt      <= 8'd0;
      occupied_cnt <= 8'd0;
    end else begin
      state <= next_state;
      // Address generator parks at (0,0) outside SCAN, so entering SCAN
      // presents cell 0 immediately and the last cell never wraps.
      if (state == S_SCAN && !scan_last) begin
        addr_idx <= addr_idx + IDX_W'(1);
        if (q_x == X_LAST) begin
          q_x <= 4'd0;
          q_y <= q_y + 5'd1;
        end else begin
          q_x <= q_x + 4'd1;
        end
      end else begin
        q_x      <= 4'd0;
        q_y      <= 5'd0;
        addr_idx <= '0;
      end
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (next_state == S_SCAN && state != S_SCAN)
        run_cnt <= 8'd0;
      else if (cap_vld && q_kind != 3'd0)
        run_cnt <= run_cnt + 8'd1;
      if (state == S_DONE)
        occupied_cnt <= run_cnt;
    end
  end

  // Stage p0: address issued to the core this cycle
  assign addr_p0 = addr_idx;
  assign vld_p0  = (state == S_SCAN);

  // Stage p1..pN: address/valid delayed to line up with q_kind
  generate
    if (QUERY_LAT == 0) begin : g_no_lat
      assign cap_addr = addr_p0;
      assign cap_vld  = vld_p0;
    end else begin : g_lat
      logic [IDX_W-1:0] addr_pn [QUERY_LAT];
      logic             vld_pn  [QUERY_LAT];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < QUERY_LAT; i++) vld_pn[i] <= 1'b0;
        end else begin
          vld_pn[0] <= vld_p0;
          for (int i = 1; i < QUERY_LAT; i++) vld_pn[i] <= vld_pn[i-1];
        end
        addr_pn[0] <= addr_p0;
        for (int i = 1; i < QUERY_LAT; i++) addr_pn[i] <= addr_pn[i-1];
      end

      assign cap_addr = addr_pn[QUERY_LAT-1];
      assign cap_vld  = vld_pn[QUERY_LAT-1];
    end
  endgenerate

  assign rd_in_range = (rd_x < COLS_L) && (rd_y < ROWS_L);
  assign rd_idx      = IDX_W'(rd_y) * IDX_W'(COLS) + IDX_W'(rd_x);

`ifdef TBS_DOUBLE_BUF_EN
  logic [2:0] bank [2][CELLS];
  logic       front;

  always_ff @(posedge clk) begin
    if (reset) begin
      front <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < CELLS; i++) bank[b][i] <= 3'd0;
    end else begin
      if (cap_vld) bank[~front][cap_addr] <= q_kind;
      // Swap at end of DONE: the last capture has already landed.
      if (state == S_DONE) front <= ~front;
    end
  end

  assign rd_cell = bank[front][rd_idx];
`else
  logic [2:0] bank [CELLS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) bank[i] <= 3'd0;
    end else if (cap_vld) begin
      bank[cap_addr] <= q_kind;
    end
  end

  assign rd_cell = bank[rd_idx];
`endif

  always_ff @(posedge clk) begin
    if (reset) rd_kind <= 3'd0;
    else       rd_kind <= rd_in_range ? rd_cell : 3'd0;
  end

endmodule

// File: tb/tb_tetris_board_scanner.sv
// Directed testbench for tetris_board_scanner with a stub core that returns
// either (x+y)%8 or a constant kind, delayed by QUERY_LAT cycles.
module tb_tetris_board_scanner;

  localparam int QL  = 1;
  localparam int DLI = (QL == 0) ? 0 : QL - 1;
`ifdef TBS_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       start;
  logic       core_ready;
  logic [3:0] q_x;
  logic [4:0] q_y;
  logic [2:0] q_kind;
  logic [3:0] rd_x;
  logic [4:0] rd_y;
  logic [2:0] rd_kind;
  logic       busy;
  logic       done;
  logic [7:0] occupied_cnt;

  tetris_board_scanner #(.QUERY_LAT(QL), .COLS(10), .ROWS(20)) dut (
    .clk(clk), .reset(reset), .start(start), .core_ready(core_ready),
    .q_x(q_x), .q_y(q_y), .q_kind(q_kind),
    .rd_x(rd_x), .rd_y(rd_y), .rd_kind(rd_kind),
    .busy(busy), .done(done), .occupied_cnt(occupied_cnt)
  );

  always #5 clk = ~clk;

  // Stub core
  logic       kind_mode;
  logic [2:0] const_kind;
  logic [2:0] kind_f;
  logic [2:0] dl [3];

  assign kind_f = kind_mode ? const_kind : 3'({1'b0, q_x} + q_y);
  always @(posedge clk) begin
    dl[0] <= kind_f;
    dl[1] <= dl[0];
    dl[2] <= dl[1];
  end
  assign q_kind = (QL == 0) ? kind_f : dl[DLI];

  int n_cmp = 0;
  int n_err = 0;

  int         done_n, done_cnt, busy_n;
  logic [2:0] rk_log [0:511];
  logic [3:0] qx_log [0:511];
  logic [4:0] qy_log [0:511];
  logic [2:0] rv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; returns #1 after that edge (cycle S+1).
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Observe ncyc cycles, the first being the current one; optionally pulse
  // start during cycle restart_at.
  task automatic watch(input int ncyc, input int restart_at);
    done_n = -1; done_cnt = 0; busy_n = 0;
    for (int n = 1; n <= ncyc; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      start     = (n == restart_at);
      rk_log[n] = rd_kind;
      qx_log[n] = q_x;
      qy_log[n] = q_y;
      if (busy) busy_n++;
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
    end
    start = 1'b0;
  endtask

  task automatic read(input logic [3:0] x, input logic [4:0] y, output logic [2:0] k);
    @(negedge clk);
    rd_x = x;
    rd_y = y;
    @(posedge clk);
    #1 k = rd_kind;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; start = 1'b0; core_ready = 1'b1;
    rd_x = 4'd3; rd_y = 5'd4; kind_mode = 1'b0; const_kind = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_qx", q_x, 0);
    check("rst_qy", q_y, 0);
    check("rst_occ", occupied_cnt, 0);
    check("rst_rd", rd_kind, 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Full scan, (x+y)%8 pattern
    kick();
    watch(215, 0);
    check("s1_done_lat", done_n, 201 + QL);
    check("s1_done_cnt", done_cnt, 1);
    check("s1_busy_cycles", busy_n, 200 + QL);
    check("s1_addr0_x", qx_log[1], 0);
    check("s1_addr1_x", qx_log[2], 1);
    check("s1_addr10_x", qx_log[11], 0);
    check("s1_addr10_y", qy_log[11], 1);
    check("s1_addr199_x", qx_log[200], 9);
    check("s1_addr199_y", qy_log[200], 19);
    check("s1_after_last_x", qx_log[201], 0);
    check("s1_after_last_y", qy_log[201], 0);
    check("s1_occ", occupied_cnt, 175);
    read(4'd3, 5'd4, rv);   check("s1_rd_3_4", rv, 7);
    read(4'd9, 5'd19, rv);  check("s1_rd_9_19", rv, 4);
    read(4'd10, 5'd0, rv);  check("rd_oor_x", rv, 0);
    read(4'd0, 5'd20, rv);  check("rd_oor_y", rv, 0);
    read(4'd15, 5'd31, rv); check("rd_oor_xy", rv, 0);

    // Start while core not ready
    core_ready = 1'b0;
    kick();
    for (int i = 0; i < 5; i++) begin
      check("wait_busy", busy, 1);
      check("wait_qx", q_x, 0);
      check("wait_qy", q_y, 0);
      @(posedge clk);
      #1;
    end
    core_ready = 1'b1;
    @(posedge clk);
    #1 core_ready = 1'b0;
    watch(215, 0);
    check("s2_first_x", qx_log[1], 0);
    check("s2_second_x", qx_log[2], 1);
    check("s2_done_lat", done_n, 201 + QL);
    check("s2_busy_cycles", busy_n, 200 + QL);
    check("s2_occ", occupied_cnt, 175);

    // Restart request mid-scan is ignored
    core_ready = 1'b1;
    kick();
    watch(400, 50);
    check("s3_done_cnt", done_cnt, 1);
    check("s3_done_lat", done_n, 201 + QL);
    check("s3_busy_cycles", busy_n, 200 + QL);
    check("s3_occ", occupied_cnt, 175);

    // Reset mid-scan
    kind_mode = 1'b1; const_kind = 3'd3;
    kick();
    watch(100, 0);
    reset = 1'b1;
    rd_x = 4'd3; rd_y = 5'd4;
    @(posedge clk);
    #1 reset = 1'b0;
    check("s4_busy", busy, 0);
    check("s4_done", done, 0);
    check("s4_occ", occupied_cnt, 0);
    check("s4_qx", q_x, 0);
    @(posedge clk);
    #1;
    check("s4_rd_3_4", rd_kind, 0);
    read(4'd0, 5'd0, rv);
    check("s4_rd_0_0", rv, 0);
    watch(300, 0);
    check("s4_no_done", done_cnt, 0);
    check("s4_no_busy", busy_n, 0);

    // Snapshot visibility: all-2 frame then all-5 frame
    const_kind = 3'd2;
    kick();
    watch(215, 0);
    check("s5a_occ", occupied_cnt, 200);
    read(4'd0, 5'd0, rv);
    check("s5a_rd_0_0", rv, 2);
    const_kind = 3'd5;
    kick();
    watch(215, 0);
    check("s5b_done_lat", done_n, 201 + QL);
    check("s5b_rd_before_cap", rk_log[2 + QL], 2);
    check("s5b_rd_after_cap", rk_log[3 + QL], DB ? 2 : 5);
    check("s5b_rd_mid", rk_log[50], DB ? 2 : 5);
    check("s5b_rd_done", rk_log[done_n + 1], DB ? 2 : 5);
    check("s5b_rd_post", rk_log[done_n + 2], 5);
    check("s5b_occ", occupied_cnt, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tetris_board_scanner.md
Name: tetris_board_scanner

Overview:
- Reader side of the tetris core's cell-query interface.
- Sweeps the core's (x, y) query port across the 10x20 playfield, captures the returned cell kind, and stores a snapshot in a local 200-cell buffer.
- The display path reads the snapshot through an independent registered port, and never drives the core's query port directly.
- Also reports how many non-empty cells the last completed snapshot held.

Parameters:
- QUERY_LAT, 1, cycles from q_x/q_y presented to q_kind valid; legal 0..3.
- COLS, 10, playfield width; query x width fixed at 4 bits.
- ROWS, 20, playfield height; query y width fixed at 5 bits.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request one full scan; sampled only in IDLE
- core_ready  in  1  core ready flag; board contents valid to query
- q_x  out  4  column presented to core
- q_y  out  5  row presented to core
- q_kind  in  3  core's cell kind for (q_x, q_y), QUERY_LAT cycles later; 0 = empty
- rd_x  in  4  display read column
- rd_y  in  5  display read row
- rd_kind  out  3  registered snapshot cell; 1-cycle latency
- busy  out  1  scan in progress
- done  out  1  1-cycle pulse when a snapshot is complete
- occupied_cnt  out  8  non-zero cells in last completed snapshot

Behaviour:
- Reset values:
  - state = IDLE.
  - q_x = 0, q_y = 0.
  - busy = 0, done = 0.
  - occupied_cnt = 0, rd_kind = 0.
  - All buffer cells = 0.
- States:
  - IDLE: start=1 and core_ready=1 -> SCAN; start=1 and core_ready=0 -> WAIT.
  - WAIT: go to SCAN on the first cycle core_ready=1. start is not re-sampled.
  - SCAN: issue one address per cycle, row-major order (y=0..19 outer, x=0..9 inner). After the last address (9,19), go to DRAIN.
  - DRAIN: wait QUERY_LAT cycles for in-flight captures, then DONE.
  - DONE: one cycle, then IDLE.
- Address timing: if SCAN is entered at cycle S+1, address k (k = y*10 + x) is on q_x/q_y during cycle S+1+k.
- Capture: q_kind for address k is written into buffer cell k at the end of cycle S+1+k+QUERY_LAT. Capture uses a QUERY_LAT-deep pipeline of the address and a valid bit.
- core_ready is sampled only to leave IDLE/WAIT. A deassertion mid-scan is ignored and the scan completes.
- busy: high in WAIT, SCAN and DRAIN; low in IDLE and DONE.
- done: high only in DONE, i.e. at cycle S+201+QUERY_LAT when started from IDLE with core_ready=1.
- occupied_cnt:
  - A running counter increments on every capture with q_kind != 0.
  - It is reset to 0 when SCAN is entered.
  - It is copied to occupied_cnt in the DONE cycle; max 200.
- q_x/q_y:
  - Return to 0 outside SCAN.
  - Address counter wraps x 9 -> 0 with y+1.
  - No wrap beyond (9,19).
- start while busy or in DONE: ignored; no queueing.
- rd port:
  - rd_kind in cycle t+1 = buffer cell (rd_x, rd_y) sampled at cycle t.
  - rd_x >= 10 or rd_y >= 20 returns 0.
  - Reads are legal in every state.
- Reset asserted mid-scan: abort immediately and clear to reset values; no done pulse.

Optional Feature:
- Macro TBS_DOUBLE_BUF_EN.
- Defined:
  - Two 200-cell banks; captures go to the back bank and the rd port reads the front bank.
  - Banks swap in the DONE cycle, so rd requests presented from the cycle after done return the new snapshot.
  - The display never sees a partially updated frame.
  - Reset clears both banks and selects bank 0 as front.
- Undefined:
  - A single bank, written in place.
  - A rd request presented the cycle after a cell's capture returns the new value (tearing allowed).

Test Plan:
- Stub core returns q_kind = (x+y)%8 with QUERY_LAT=1; start pulse at cycle 10 with core_ready=1:
  - done at cycle 212.
  - busy high cycles 11..211.
  - rd(3,4) returns 7; rd(9,19) returns 4.
  - occupied_cnt = 175.
- start with core_ready=0 for 5 cycles: busy high and q_x/q_y stay 0 while waiting. First address (0,0) appears the cycle after core_ready rises. done follows 201+QUERY_LAT cycles after that.
- Second start pulse at cycle 50 of an active scan: ignored; exactly one done pulse; occupied_cnt unchanged from the first scan's result.
- Reset asserted at cycle 100 of a scan:
  - No done pulse.
  - busy = 0 and occupied_cnt = 0.
  - rd(0,0) returns 0 the cycle after reset releases.
- Out-of-range reads rd(10,0), rd(0,20), rd(15,31) -> rd_kind 0; QUERY_LAT=0 and 3 builds capture identically to the first scenario, with done at S+201 and S+204.
- With TBS_DOUBLE_BUF_EN: first scan all kind=2, second scan all kind=5. During the second scan, rd(0,0) returns 2; from the cycle after done it returns 5. Without the macro, rd(0,0) returns 5 from the cycle after cell 0's capture.
